// File: rtl/mem_bus_sequencer.sv
// Memory-bus ownership sequencer: BOOT -> RUN <-> PAUSED, with undriven turnaround gaps on owner changes.
// Optional breakpoint trigger enabled by defining MEM_BUS_SEQ_BREAKPOINT_EN.

module mem_bus_sequencer_chk (
    input logic i_clk,
    input logic i_rstn,
    input logic isBooted,
    input logic isPaused,
    input logic disableDrive,
    input logic coreStall,
    input logic jtagReady
);
    a_turnGap: assert property (@(posedge i_clk) disable iff (!i_rstn)
        ((isBooted != $past(isBooted)) || (isPaused != $past(isPaused))) |-> disableDrive);

    a_jtagVsCore: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(jtagReady && !coreStall));
endmodule

module mem_bus_sequencer #(
    parameter int TURN_CYCLES = 2,
    parameter int DRAIN_MAX   = 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_bootDone,
    input  logic        i_pauseReq,
    input  logic        i_resumeReq,
    input  logic        i_coreIdle,
    output logic        o_isBooted,
    output logic        o_isPaused,
    output logic        o_disableDrive,
    output logic        o_coreStall,
    output logic        o_jtagReady,
    output logic        o_drainErr
`ifdef MEM_BUS_SEQ_BREAKPOINT_EN
    ,
    input  logic        i_bpWr,
    input  logic [15:0] i_bpAddr,
    input  logic        i_bpClr,
    input  logic [15:0] i_coreAddr,
    input  logic        i_coreEn,
    output logic        o_bpHit
`endif
);
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_TURN_B = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_TURN_P = 3'd4,
        ST_PAUSED = 3'd5,
        ST_TURN_R = 3'd6
    } state_t;

    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    // Output vector {isBooted, isPaused, disableDrive, coreStall, jtagReady} for a given state.
    function automatic logic [4:0] stateOuts(input state_t st);
        case (st)
            ST_BOOT:   stateOuts = 5'b00010;
            ST_TURN_B: stateOuts = 5'b10110;
            ST_RUN:    stateOuts = 5'b10000;
            ST_DRAIN:  stateOuts = 5'b10010;
            ST_TURN_P: stateOuts = 5'b11110;
            ST_PAUSED: stateOuts = 5'b11011;
            ST_TURN_R: stateOuts = 5'b10110;
            default:   stateOuts = 5'b00010;
        endcase
    endfunction

    state_t     state_r;
    state_t     nextState_s;
    logic [3:0] turnCnt_r;
    logic [3:0] turnCnt_s;
    logic [7:0] drainCnt_r;
    logic [7:0] drainCnt_s;
    logic       pausePending_r;
    logic       pausePending_s;
    logic       drainErr_r;
    logic       drainErr_s;
    logic       isBooted_r;
    logic       isPaused_r;
    logic       disableDrive_r;
    logic       coreStall_r;
    logic       jtagReady_r;
    logic       pauseIn_s;

`ifdef MEM_BUS_SEQ_BREAKPOINT_EN
    logic [15:0] bpAddr_r;
    logic        bpValid_r;
    logic        bpHit_r;
    logic        bpMatch_s;

    assign bpMatch_s = (state_r == ST_RUN) && i_coreEn && bpValid_r && (i_coreAddr == bpAddr_r);
    assign pauseIn_s = i_pauseReq | bpMatch_s;

    // Breakpoint register; a write wins over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bpAddr_r  <= 16'h0000;
            bpValid_r <= 1'b0;
        end else if (i_bpWr) begin
            bpAddr_r  <= i_bpAddr;
            bpValid_r <= 1'b1;
        end else if (i_bpClr) begin
            bpValid_r <= 1'b0;
        end else begin
            bpValid_r <= bpValid_r;
        end
    end

    // Sticky hit flag, cleared on the resume edge into TURN_R.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bpHit_r <= 1'b0;
        end else if ((state_r == ST_PAUSED) && i_resumeReq) begin
            bpHit_r <= 1'b0;
        end else if (bpMatch_s) begin
            bpHit_r <= 1'b1;
        end else begin
            bpHit_r <= bpHit_r;
        end
    end

    assign o_bpHit = bpHit_r;
`else
    assign pauseIn_s = i_pauseReq;
`endif

    // Next-state, counter, pending-pause and drain-error computation.
    always_comb begin
        nextState_s    = state_r;
        turnCnt_s      = turnCnt_r;
        drainCnt_s     = drainCnt_r;
        pausePending_s = pausePending_r;
        drainErr_s     = drainErr_r;
        case (state_r)
            ST_BOOT: begin
                if (pauseIn_s) begin
                    pausePending_s = 1'b1;
                end else begin
                    pausePending_s = pausePending_r;
                end
                if (i_bootDone) begin
                    nextState_s = ST_TURN_B;
                    turnCnt_s   = 4'd0;
                end else begin
                    nextState_s = ST_BOOT;
                end
            end
            ST_TURN_B: begin
                if (pauseIn_s) begin
                    pausePending_s = 1'b1;
                end else begin
                    pausePending_s = pausePending_r;
                end
                if (turnCnt_r != TURN_LAST) begin
                    turnCnt_s = turnCnt_r + 4'd1;
                end else if (pausePending_r) begin
                    nextState_s    = ST_DRAIN;
                    drainCnt_s     = 8'd0;
                    pausePending_s = 1'b0;
                end else begin
                    nextState_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pauseIn_s || pausePending_r) begin
                    nextState_s    = ST_DRAIN;
                    drainCnt_s     = 8'd0;
                    pausePending_s = 1'b0;
                end else begin
                    nextState_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (i_coreIdle) begin
                    nextState_s = ST_TURN_P;
                    turnCnt_s   = 4'd0;
                end else if (drainCnt_r == DRAIN_LAST) begin
                    nextState_s = ST_TURN_P;
                    turnCnt_s   = 4'd0;
                    drainErr_s  = 1'b1;
                end else begin
                    drainCnt_s = drainCnt_r + 8'd1;
                end
            end
            ST_TURN_P: begin
                if (turnCnt_r == TURN_LAST) begin
                    nextState_s = ST_PAUSED;
                end else begin
                    turnCnt_s = turnCnt_r + 4'd1;
                end
            end
            ST_PAUSED: begin
                if (i_resumeReq) begin
                    nextState_s = ST_TURN_R;
                    turnCnt_s   = 4'd0;
                    drainErr_s  = 1'b0;
                end else begin
                    nextState_s = ST_PAUSED;
                end
            end
            ST_TURN_R: begin
                if (pauseIn_s) begin
                    pausePending_s = 1'b1;
                end else begin
                    pausePending_s = pausePending_r;
                end
                if (turnCnt_r == TURN_LAST) begin
                    nextState_s = ST_RUN;
                end else begin
                    turnCnt_s = turnCnt_r + 4'd1;
                end
            end
            default: begin
                nextState_s = ST_BOOT;
            end
        endcase
    end

    // State register; outputs are registered from the state being entered.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r        <= ST_BOOT;
            turnCnt_r      <= 4'd0;
            drainCnt_r     <= 8'd0;
            pausePending_r <= 1'b0;
            drainErr_r     <= 1'b0;
            isBooted_r     <= 1'b0;
            isPaused_r     <= 1'b0;
            disableDrive_r <= 1'b0;
            coreStall_r    <= 1'b1;
            jtagReady_r    <= 1'b0;
        end else begin
            state_r        <= nextState_s;
            turnCnt_r      <= turnCnt_s;
            drainCnt_r     <= drainCnt_s;
            pausePending_r <= pausePending_s;
            drainErr_r     <= drainErr_s;
            {isBooted_r, isPaused_r, disableDrive_r, coreStall_r, jtagReady_r} <= stateOuts(nextState_s);
        end
    end

    assign o_isBooted     = isBooted_r;
    assign o_isPaused     = isPaused_r;
    assign o_disableDrive = disableDrive_r;
    assign o_coreStall    = coreStall_r;
    assign o_jtagReady    = jtagReady_r;
    assign o_drainErr     = drainErr_r;

    mem_bus_sequencer_chk u_chk (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .isBooted     (isBooted_r),
        .isPaused     (isPaused_r),
        .disableDrive (disableDrive_r),
        .coreStall    (coreStall_r),
        .jtagReady    (jtagReady_r)
    );
endmodule
